sd_host_regfile: RTL and testbench
==================================

// Module: sd_host_regfile
// PURPOSE
//  Parametrised register file for the SD host controller: CPU req/ack register bus with byte enables, per-register access types (RW/RO/W1C).
//  Hardware side loads responses and present state, and sets interrupt status bits. Outputs a level interrupt and a command-start strobe.
//  Sits between the CPU bus and the command/data engines; successor of the flat 32-bit register array.
// PARAMETERS
//  DATA_WIDTH  32      register/bus width; multiple of 16
//  ADDR_WIDTH  5       word address width
//  NUM_REGS    25      implemented registers, 0..NUM_REGS-1; NUM_REGS <= 2**ADDR_WIDTH
//  CAPS_VALUE  32'h0   reset/constant value of Capabilities (reg 16)
//  HC_VERSION  16'h0002 constant in upper half of reg 19
// PORTS
//  clk           in   1              rising-edge clock
//  reset         in   1              asynchronous, active-high reset
//  req           in   1              CPU request
//  rw            in   1              1=read, 0=write
//  addr          in   ADDR_WIDTH     word address
//  be            in   DATA_WIDTH/8   write byte enables
//  data_in       in   DATA_WIDTH     write data
//  data_out      out  DATA_WIDTH     read data, valid with ack
//  ack           out  1              one-cycle completion pulse
//  err           out  1              out-of-range address, valid with ack
//  resp_we       in   1              load response regs 4..7
//  resp_data     in   4*DATA_WIDTH   response; [DATA_WIDTH-1:0] -> reg 4
//  pstate        in   DATA_WIDTH     present state, sampled into reg 9 every cycle
//  irq_set       in   DATA_WIDTH     set pulses for interrupt status reg 12
//  irq           out  1              level interrupt
//  cmd_start     out  1              one-cycle strobe: Command written
// BEHAVIOUR
//  - Reset: every register clears to 0, except reg 16 = CAPS_VALUE and reg19[31:16] = HC_VERSION.
//    Reset values of outputs: data_out=0, ack=0, err=0, irq=0, cmd_start=0.
//  - Handshake: a transaction is accepted on a clk edge with req=1 and ack=0.
//    ack=1 for exactly the next cycle, with data_out/err valid. req is ignored while ack=1.
//    A held req therefore yields one transaction every 2 cycles. data_out holds its value between reads.
//  - Write: bytes with be[i]=1 are updated on the acceptance edge.
//  - Access types:
//    RW: 0-3, 8, 10, 11, 13, 14, 20, 22-24.
//    RO: 4-7, 9, 15-19, 21; CPU writes are dropped but still acked with err=0.
//    W1C: 12; a written 1 clears the bit.
//  - Interrupt status: reg12 <= (reg12 & ~(wr_mask)) | irq_set.
//    If a set and a clear hit the same bit in the same cycle, the set wins.
//  - Out of range (addr >= NUM_REGS): a read returns 0, a write is dropped; err=1 with ack.
//  - resp_we loads regs 4..7 from resp_data on the edge. It has priority over nothing, because those regs are RO to the CPU.
//  - irq = |(reg12 & reg13 & reg14), registered, so it is valid the cycle after its cause.
//  - cmd_start pulses the cycle after an accepted write to reg 3 with be[3] or be[2] set.
//    This strobe is coincident with ack.
//  - A CPU read of a register updated by hardware on the same edge returns the pre-update value.
//  - Reset asserted mid-transaction aborts it: no ack, all state is reset.
// CONFIGURATION
//  SD_REG_SWRST_EN defined: reg11[31:24] is Software_Reset.
//    Writing bit0=1 resets all RW and W1C registers to their reset values on the following edge, and reset bits self-clear one cycle after the write.
//    The write itself is acked normally.
//  Undefined: reg11[31:24] is plain RW storage with no side effects.
// STRUCTURE
//  Package sd_reg_pkg holds:
//    - the register index localparams (REG_SDMA=0 .. REG_TIMEOUT=24);
//    - the access-type enum {ACC_RW, ACC_RO, ACC_W1C};
//    - the function acc_type(idx);
//    - byte-merge function be_merge(old, new, be).
//  Sub-module sd_irq_status: W1C status reg, enable masks, irq generation.
//  The remaining registers are a generate loop over NUM_REGS.
// TESTING
//  1. Reset, read reg16 -> data_out=CAPS_VALUE, ack one cycle after req, err=0. Read reg2 -> 0.
//  2. Write reg2 with 32'hA5A5_1234, be=4'b0011; read back -> 32'h0000_1234.
//  3. Write 32'hFFFF_FFFF to reg5 -> ack, err=0. Read reg5 -> unchanged. Then resp_we with word1=32'hDEAD_BEEF -> read reg5 = 32'hDEAD_BEEF.
//  4. irq_set=32'h1; with reg13=reg14=32'h1 -> irq=1 the next cycle.
//     Write reg12=32'h1 -> cleared, irq=0. Simultaneous irq_set=1 with W1C write -> bit stays 1.
//  5. Write reg3 be=4'b1100 -> cmd_start one pulse with ack. Write addr=30 -> ack, err=1; read addr=30 -> data_out=0, err=1.
//  6. SD_REG_SWRST_EN: preload reg0=32'h1234, write reg11=32'h0100_0000 -> reg0 reads 0 and reg11[31:24] reads 0. Without the macro, reg11 reads 32'h0100_0000.

Source files
------------

// File: rtl/sd_reg_pkg.sv
// Register map, access types and byte-merge helper
// shared by the SD host register file blocks.
package sd_reg_pkg;

  localparam int REG_SDMA      = 0;
  localparam int REG_BLK       = 1;
  localparam int REG_ARG       = 2;
  localparam int REG_CMD       = 3;
  localparam int REG_RESP0     = 4;
  localparam int REG_RESP3     = 7;
  localparam int REG_BUF       = 8;
  localparam int REG_PSTATE    = 9;
  localparam int REG_HOST_CTRL = 10;
  localparam int REG_CLK_CTRL  = 11;
  localparam int REG_INT_STAT  = 12;
  localparam int REG_INT_EN    = 13;
  localparam int REG_SIG_EN    = 14;
  localparam int REG_ACMD_ERR  = 15;
  localparam int REG_CAPS      = 16;
  localparam int REG_CAPS2     = 17;
  localparam int REG_MAX_CUR   = 18;
  localparam int REG_VERSION   = 19;
  localparam int REG_FORCE_EVT = 20;
  localparam int REG_ADMA_ERR  = 21;
  localparam int REG_ADMA_LO   = 22;
  localparam int REG_ADMA_HI   = 23;
  localparam int REG_TIMEOUT   = 24;

  localparam int MAX_DW = 256;
  localparam int MAX_NB = MAX_DW / 8;

  typedef enum logic [1:0] {
    ACC_RW,
    ACC_RO,
    ACC_W1C
  } acc_t;

  function automatic acc_t acc_type(input int idx);
    acc_t t;
    t = ACC_RO;
    unique case (1'b1)
      idx == REG_INT_STAT: t = ACC_W1C;
      (idx inside {[0:3], 8, 10, 11, 13, 14, 20, [22:24]}):
        t = ACC_RW;
      default: t = ACC_RO;
    endcase
    return t;
  endfunction

  function automatic logic [MAX_DW-1:0] be_merge(
    input logic [MAX_DW-1:0] old_v,
    input logic [MAX_DW-1:0] new_v,
    input logic [MAX_NB-1:0] be
  );
    logic [MAX_DW-1:0] r;
    r = old_v;
    for (int i = 0; i < MAX_NB; i++)
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/sd_host_regfile_if.sv
// CPU register bus: req/ack handshake, rw, addr, be, data, err.
// master = CPU side, slave = register file.
interface sd_host_regfile_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                    req;
  logic                    rw;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   data_in;
  logic [DATA_WIDTH-1:0]   data_out;
  logic                    ack;
  logic                    err;

  modport master (
    output req, rw, addr, be, data_in,
    input  data_out, ack, err
  );

  modport slave (
    input  req, rw, addr, be, data_in,
    output data_out, ack, err
  );
endinterface

// File: rtl/sd_irq_status.sv
// Interrupt status (W1C), status enable, signal enable and level irq.
// Ports: clk/reset, write strobes + data/be, swrst, irq_set; regs, irq.
module sd_irq_status
  import sd_reg_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    swrst,
  input  logic                    wr_stat,
  input  logic                    wr_en,
  input  logic                    wr_sig,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   irq_set,
  output logic [DATA_WIDTH-1:0]   stat,
  output logic [DATA_WIDTH-1:0]   int_en,
  output logic [DATA_WIDTH-1:0]   sig_en,
  output logic                    irq
);
  localparam int DW = DATA_WIDTH;
  localparam int NB = DW / 8;

  function automatic logic [DW-1:0] merge(
    input logic [DW-1:0] o,
    input logic [DW-1:0] n,
    input logic [NB-1:0] b
  );
    return DW'(be_merge(MAX_DW'(o), MAX_DW'(n), MAX_NB'(b)));
  endfunction

  logic [DW-1:0] clr, stat_d, en_d, sig_d;

  always_comb begin
    clr    = '0;
    stat_d = stat;
    en_d   = int_en;
    sig_d  = sig_en;
    if (wr_stat) clr = merge('0, wdata, be);
    // set is OR-ed last so it beats a same-cycle clear
    stat_d = ((swrst ? '0 : stat) & ~clr) | irq_set;
    if (swrst)       en_d = '0;
    else if (wr_en)  en_d = merge(int_en, wdata, be);
    if (swrst)       sig_d = '0;
    else if (wr_sig) sig_d = merge(sig_en, wdata, be);
  end

  // irq tracks the registers' new values, so it moves on the same
  // edge as the status bit that causes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat   <= '0;
      int_en <= '0;
      sig_en <= '0;
      irq    <= 1'b0;
    end else begin
      stat   <= stat_d;
      int_en <= en_d;
      sig_en <= sig_d;
      irq    <= |(stat_d & en_d & sig_d);
    end
  end
endmodule

// File: rtl/sd_host_regfile.sv
// SD host register file: CPU bus (sd_host_regfile_if.slave), resp/pstate
// loads, irq, cmd_start. Option macro: SD_REG_SWRST_EN.
module sd_host_regfile
  import sd_reg_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    NUM_REGS   = 25,
  parameter logic [DATA_WIDTH-1:0] CAPS_VALUE = '0,
  parameter logic [15:0]           HC_VERSION = 16'h0002
) (
  input  logic                    clk,
  input  logic                    reset,
  sd_host_regfile_if.slave        bus,
  input  logic                    resp_we,
  input  logic [4*DATA_WIDTH-1:0] resp_data,
  input  logic [DATA_WIDTH-1:0]   pstate,
  input  logic [DATA_WIDTH-1:0]   irq_set,
  output logic                    irq,
  output logic                    cmd_start
);
  localparam int DW = DATA_WIDTH;
  localparam int NB = DW / 8;
  localparam int NA = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(NUM_REGS);

  function automatic logic [DW-1:0] merge(
    input logic [DW-1:0] o,
    input logic [DW-1:0] n,
    input logic [NB-1:0] b
  );
    return DW'(be_merge(MAX_DW'(o), MAX_DW'(n), MAX_NB'(b)));
  endfunction

  function automatic logic hit(
    input logic [ADDR_WIDTH-1:0] a,
    input int                    idx
  );
    return a == ADDR_WIDTH'(idx);
  endfunction

  logic [DW-1:0] rview [NA];
  logic          accept, wr, in_range, swrst;
  logic [DW-1:0] stat, int_en, sig_en;

  assign accept   = bus.req & ~bus.ack;
  assign wr       = accept & ~bus.rw;
  assign in_range = {1'b0, bus.addr} < LIMIT;

`ifdef SD_REG_SWRST_EN
  // Software_Reset bit0 lives in reg11; RW/W1C clear on the next edge,
  // which also clears the bit itself
  assign swrst = rview[REG_CLK_CTRL][DW-8];
`else
  assign swrst = 1'b0;
`endif

  sd_irq_status #(.DATA_WIDTH(DW)) u_irq (
    .clk     (clk),
    .reset   (reset),
    .swrst   (swrst),
    .wr_stat (wr & hit(bus.addr, REG_INT_STAT)),
    .wr_en   (wr & hit(bus.addr, REG_INT_EN)),
    .wr_sig  (wr & hit(bus.addr, REG_SIG_EN)),
    .wdata   (bus.data_in),
    .be      (bus.be),
    .irq_set (irq_set),
    .stat    (stat),
    .int_en  (int_en),
    .sig_en  (sig_en),
    .irq     (irq)
  );

  for (genvar i = 0; i < NA; i++) begin : g_reg
    if (i >= NUM_REGS) begin : g_none
      assign rview[i] = '0;
    end else if (i == REG_INT_STAT) begin : g_stat
      assign rview[i] = stat;
    end else if (i == REG_INT_EN) begin : g_en
      assign rview[i] = int_en;
    end else if (i == REG_SIG_EN) begin : g_sig
      assign rview[i] = sig_en;
    end else if (acc_type(i) == ACC_RW) begin : g_rw
      logic [DW-1:0] q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)                      q <= '0;
        else if (swrst)                 q <= '0;
        else if (wr && hit(bus.addr, i)) q <= merge(q, bus.data_in, bus.be);
      end
      assign rview[i] = q;
    end else if (i >= REG_RESP0 && i <= REG_RESP3) begin : g_resp
      logic [DW-1:0] q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)        q <= '0;
        else if (resp_we) q <= resp_data[(i-REG_RESP0)*DW +: DW];
      end
      assign rview[i] = q;
    end else if (i == REG_PSTATE) begin : g_pstate
      logic [DW-1:0] q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= '0;
        else       q <= pstate;
      end
      assign rview[i] = q;
    end else if (i == REG_CAPS) begin : g_caps
      assign rview[i] = CAPS_VALUE;
    end else if (i == REG_VERSION) begin : g_ver
      assign rview[i] = {HC_VERSION, {(DW-16){1'b0}}};
    end else begin : g_zero
      assign rview[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.ack      <= 1'b0;
      bus.err      <= 1'b0;
      bus.data_out <= '0;
      cmd_start    <= 1'b0;
    end else begin
      bus.ack   <= accept;
      bus.err   <= accept & ~in_range;
      cmd_start <= wr & hit(bus.addr, REG_CMD) & (|bus.be[NB-1:NB/2]);
      if (accept & bus.rw) bus.data_out <= rview[bus.addr];
    end
  end
endmodule

// File: tb/tb_sd_host_regfile.sv
// Self-checking bench for sd_host_regfile: directed steps then random
// traffic against a register-map reference model.
module tb_sd_host_regfile;
  localparam logic [31:0] CAPS = 32'hC0DE_5A01;
  localparam logic [31:0] VER  = 32'h0002_0000;

  logic         clk = 1'b0;
  logic         reset;
  logic         resp_we;
  logic [127:0] resp_data;
  logic [31:0]  pstate;
  logic [31:0]  irq_set;
  logic         irq;
  logic         cmd_start;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sd_host_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  sd_host_regfile #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .NUM_REGS   (25),
    .CAPS_VALUE (CAPS),
    .HC_VERSION (16'h0002)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .resp_we   (resp_we),
    .resp_data (resp_data),
    .pstate    (pstate),
    .irq_set   (irq_set),
    .irq       (irq),
    .cmd_start (cmd_start)
  );

  logic [31:0] m [32];
  logic [31:0] m_dout;
  logic        m_ack, m_err, m_irq, m_cmd;

  function automatic bit is_rw(input int a);
    return a inside {[0:3], 8, 10, 11, 13, 14, 20, [22:24]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 32; k++) m[k] = '0;
    m[16]  = CAPS;
    m[19]  = VER;
    m_dout = '0;
    m_ack  = 1'b0;
    m_err  = 1'b0;
    m_irq  = 1'b0;
    m_cmd  = 1'b0;
  endtask

  task automatic model_edge();
    logic [31:0] nm [32];
    logic [31:0] mask;
    bit acc, swr;
    int a;
    nm  = m;
    acc = bus.req && !m_ack;
    a   = int'(bus.addr);
    for (int k = 0; k < 4; k++) mask[8*k +: 8] = {8{bus.be[k]}};
    nm[9] = pstate;
    if (resp_we)
      for (int k = 0; k < 4; k++) nm[4+k] = resp_data[32*k +: 32];
`ifdef SD_REG_SWRST_EN
    swr = m[11][24];
`else
    swr = 1'b0;
`endif
    if (swr) begin
      for (int r = 0; r < 25; r++)
        if (is_rw(r) || r == 12) nm[r] = '0;
    end else if (acc && !bus.rw && a < 25) begin
      if (is_rw(a))
        nm[a] = (m[a] & ~mask) | (bus.data_in & mask);
      else if (a == 12)
        nm[12] = nm[12] & ~(bus.data_in & mask);
    end
    nm[12] = nm[12] | irq_set;
    m_irq  = |(nm[12] & nm[13] & nm[14]);
    m_cmd  = acc && !bus.rw && a == 3 && (bus.be[3] || bus.be[2]);
    m_err  = acc && a >= 25;
    if (acc && bus.rw) m_dout = (a < 25) ? m[a] : 32'h0;
    m_ack = acc;
    m     = nm;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("ack", 32'(bus.ack), 32'(m_ack));
    chk("err", 32'(bus.err), 32'(m_err));
    chk("data_out", bus.data_out, m_dout);
    chk("irq", 32'(irq), 32'(m_irq));
    chk("cmd_start", 32'(cmd_start), 32'(m_cmd));
  endtask

  task automatic drive(input bit r, input int a, input logic [3:0] b,
                       input logic [31:0] d);
    bus.req     = 1'b1;
    bus.rw      = r;
    bus.addr    = 5'(a);
    bus.be      = b;
    bus.data_in = d;
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] b);
    drive(1'b0, a, b, d);
    tick();
    bus.req = 1'b0;
    tick();
  endtask

  task automatic rd(input int a, output logic [31:0] d, output logic e);
    drive(1'b1, a, 4'h0, 32'h0);
    tick();
    d = bus.data_out;
    e = bus.err;
    bus.req = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    reset     = 1'b1;
    bus.req   = 1'b0;
    bus.rw    = 1'b0;
    bus.addr  = '0;
    bus.be    = '0;
    bus.data_in = '0;
    resp_we   = 1'b0;
    resp_data = '0;
    pstate    = 32'h0000_00F0;
    irq_set   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_ack", 32'(bus.ack), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_dout", bus.data_out, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_cmd", 32'(cmd_start), 32'h0);

    drive(1'b1, 16, 4'h0, 32'h0);
    tick();
    chk("caps_ack", 32'(bus.ack), 32'h1);
    chk("caps_val", bus.data_out, CAPS);
    chk("caps_err", 32'(bus.err), 32'h0);
    bus.req = 1'b0;
    tick();
    chk("caps_ack_drop", 32'(bus.ack), 32'h0);
    rd(2, d, e);
    chk("reg2_rst", d, 32'h0);
    rd(19, d, e);
    chk("version", d, VER);

    wr(2, 32'hA5A5_1234, 4'b0011);
    rd(2, d, e);
    chk("reg2_be", d, 32'h0000_1234);

    drive(1'b0, 5, 4'hF, 32'hFFFF_FFFF);
    tick();
    chk("ro_wr_ack", 32'(bus.ack), 32'h1);
    chk("ro_wr_err", 32'(bus.err), 32'h0);
    bus.req = 1'b0;
    tick();
    rd(5, d, e);
    chk("ro_unchanged", d, 32'h0);
    resp_we   = 1'b1;
    resp_data = {32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0};
    tick();
    resp_we = 1'b0;
    rd(5, d, e);
    chk("resp_word1", d, 32'hDEAD_BEEF);
    rd(9, d, e);
    chk("pstate", d, 32'h0000_00F0);

    wr(13, 32'h1, 4'hF);
    wr(14, 32'h1, 4'hF);
    irq_set = 32'h1;
    tick();
    irq_set = '0;
    chk("irq_set", 32'(irq), 32'h1);
    wr(12, 32'h1, 4'hF);
    chk("irq_clr", 32'(irq), 32'h0);
    rd(12, d, e);
    chk("stat_clr", d, 32'h0);
    irq_set = 32'h1;
    tick();
    drive(1'b0, 12, 4'hF, 32'h1);
    tick();
    irq_set = '0;
    bus.req = 1'b0;
    tick();
    rd(12, d, e);
    chk("set_beats_clr", d, 32'h1);
    chk("irq_held", 32'(irq), 32'h1);

    drive(1'b0, 3, 4'b1100, 32'h1234_0000);
    tick();
    chk("cmd_pulse", 32'(cmd_start), 32'h1);
    chk("cmd_ack", 32'(bus.ack), 32'h1);
    bus.req = 1'b0;
    tick();
    chk("cmd_drop", 32'(cmd_start), 32'h0);
    drive(1'b0, 30, 4'hF, 32'h5555_5555);
    tick();
    chk("oor_wr_err", 32'(bus.err), 32'h1);
    bus.req = 1'b0;
    tick();
    rd(30, d, e);
    chk("oor_rd_val", d, 32'h0);
    chk("oor_rd_err", 32'(e), 32'h1);

    drive(1'b1, 2, 4'h0, 32'h0);
    for (int k = 0; k < 6; k++) tick();
    bus.req = 1'b0;
    tick();

    wr(0, 32'h1234, 4'hF);
    wr(11, 32'h0100_0000, 4'hF);
    tick();
    rd(0, d, e);
`ifdef SD_REG_SWRST_EN
    chk("swrst_reg0", d, 32'h0);
    rd(11, d, e);
    chk("swrst_self_clr", d, 32'h0);
`else
    chk("noswrst_reg0", d, 32'h1234);
    rd(11, d, e);
    chk("noswrst_reg11", d, 32'h0100_0000);
`endif

    wr(1, 32'hCAFE_F00D, 4'hF);
    drive(1'b0, 1, 4'hF, 32'h1111_1111);
    #3 reset = 1'b1;
    #1;
    model_reset();
    chk("abort_ack", 32'(bus.ack), 32'h0);
    chk("abort_dout", bus.data_out, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    bus.req = 1'b0;
    rd(1, d, e);
    chk("abort_reg1", d, 32'h0);

    for (int n = 0; n < 400; n++) begin
      bus.req     = ($urandom_range(0, 3) != 0);
      bus.rw      = $urandom_range(0, 1);
      bus.addr    = 5'($urandom_range(0, 31));
      bus.be      = 4'($urandom);
      bus.data_in = $urandom;
      resp_we     = ($urandom_range(0, 7) == 0);
      resp_data   = {$urandom, $urandom, $urandom, $urandom};
      pstate      = $urandom;
      irq_set     = ($urandom_range(0, 3) == 0) ?
                    (32'h1 << $urandom_range(0, 31)) : 32'h0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
